// File: rtl/conv_out_serializer_4ch_pkg.sv
// ---------------------------------------------------------------------------
// conv_out_serializer_4ch_pkg
// Shared constants and types for the 4-channel convolution output serializer.
//   NUM_CH         : channels per pixel (4)
//   CH_IDX_W       : width of the channel index (2)
//   CH_LAST        : index of the final channel of a pixel
//   DEFAULT_DATA_W : default channel sample width
//   pixel_t        : packed 4-channel pixel at the default sample width,
//                    channel 0 in the least significant slice
//   is_last_ch()   : true when a channel index addresses the final channel
// ---------------------------------------------------------------------------
package conv_out_serializer_4ch_pkg;

    localparam int NUM_CH         = 4;
    localparam int CH_IDX_W       = 2;
    localparam int DEFAULT_DATA_W = 32;

    localparam logic [CH_IDX_W-1:0] CH_LAST = 2'd3;

    typedef logic [NUM_CH-1:0][DEFAULT_DATA_W-1:0] pixel_t;

    function automatic logic is_last_ch(input logic [CH_IDX_W-1:0] idx);
        return (idx == CH_LAST);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// ---------------------------------------------------------------------------
// pixel_fifo
// Synchronous FIFO holding whole pixels. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is ignored and the
// caller decides how to flag the drop. Storage is not reset.
// Parameters:
//   WIDTH : entry width in bits
//   DEPTH : number of entries, power of two, at least 2
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset (clears pointers and count)
//   push  : write wdata at the tail
//   pop   : release the head entry
//   wdata : entry to write
//   rdata : current head entry (meaningless while empty)
//   full  : DEPTH entries held
//   empty : no entries held
//   count : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module pixel_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             wr_en_s;
    logic             rd_en_s;

    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // A full FIFO still takes a write when the head leaves this cycle; the
    // slot being written is the one just released.
    assign rd_en_s = pop & ~empty_s;
    assign wr_en_s = push & (~full_s | rd_en_s);

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/conv_out_serializer_4ch.sv
// ---------------------------------------------------------------------------
// conv_out_serializer_4ch
// Buffers 4-channel pixels from a convolution layer (no backpressure on the
// input side) and emits them one channel sample per transfer, channel 0
// first, under a valid/ready handshake. Pixels arriving while the buffer is
// full and no pop happens are dropped and recorded in a sticky flag.
// Optional feature macro: SERIALIZER_FRAME_LAST_EN -- when defined, a popped
// pixel counter marks channel 3 of the final pixel of each frame on last_out;
// when undefined, last_out is tied low and no counter is built.
// Parameters:
//   Datawidth  : channel sample width
//   FIFO_DEPTH : pixels buffered, power of two, at least 2
//   IMG_Width  : pixels per row
//   IMG_Height : rows per frame
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   valid_in  : In_0..In_3 carry a pixel this cycle
//   In_0..3   : channel samples of the incoming pixel
//   ready_in  : downstream accepts Out this cycle
//   valid_out : Out/ch_idx valid (buffer non-empty)
//   Out       : current channel sample, 0 while valid_out is low
//   ch_idx    : channel number of Out
//   last_out  : Out is channel 3 of the last pixel of a frame
//   overflow  : sticky, a pixel was dropped since reset
// ---------------------------------------------------------------------------
module conv_out_serializer_4ch
    import conv_out_serializer_4ch_pkg::*;
#(
    parameter int Datawidth  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int IMG_Width  = 3,
    parameter int IMG_Height = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [Datawidth-1:0] In_0,
    input  logic [Datawidth-1:0] In_1,
    input  logic [Datawidth-1:0] In_2,
    input  logic [Datawidth-1:0] In_3,
    input  logic                 ready_in,
    output logic                 valid_out,
    output logic [Datawidth-1:0] Out,
    output logic [CH_IDX_W-1:0]  ch_idx,
    output logic                 last_out,
    output logic                 overflow
);

    localparam int PIX_W     = NUM_CH * Datawidth;
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int FRAME_PIX = IMG_Width * IMG_Height;

    typedef logic [NUM_CH-1:0][Datawidth-1:0] pix_t;

    pix_t                wr_pix_s;
    pix_t                head_s;
    logic [PIX_W-1:0]    fifo_rdata_s;
    logic [CNT_W-1:0]    fifo_count_s;
    logic                full_s;
    logic                empty_s;
    logic                valid_s;
    logic                xfer_s;
    logic                pop_s;
    logic                drop_s;
    logic [CH_IDX_W-1:0] ch_idx_r;
    logic                overflow_r;
    logic                unused_s;

    // Pack the incoming channels, channel 0 in the low slice.
    always_comb begin
        wr_pix_s    = '{default: {Datawidth{1'b0}}};
        wr_pix_s[0] = In_0;
        wr_pix_s[1] = In_1;
        wr_pix_s[2] = In_2;
        wr_pix_s[3] = In_3;
    end

    pixel_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pixel_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (valid_in),
        .pop   (pop_s),
        .wdata (wr_pix_s),
        .rdata (fifo_rdata_s),
        .full  (full_s),
        .empty (empty_s),
        .count (fifo_count_s)
    );

    assign head_s  = pix_t'(fifo_rdata_s);
    assign valid_s = ~empty_s;
    assign xfer_s  = valid_s & ready_in;
    // The head pixel leaves only after its last channel has been taken.
    assign pop_s   = xfer_s & is_last_ch(ch_idx_r);
    assign drop_s  = valid_in & full_s & ~pop_s;

    // Channel index advances per transfer and wraps 3 -> 0 with the pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_idx_r <= {CH_IDX_W{1'b0}};
        end else if (xfer_s) begin
            ch_idx_r <= ch_idx_r + CH_IDX_W'(1);
        end else begin
            ch_idx_r <= ch_idx_r;
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

`ifdef SERIALIZER_FRAME_LAST_EN
    localparam int PIX_CNT_W = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

    logic [PIX_CNT_W-1:0] pix_cnt_r;
    logic                 frame_end_s;

    assign frame_end_s = (pix_cnt_r == PIX_CNT_W'(FRAME_PIX - 1));

    // Popped-pixel position within the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt_r <= {PIX_CNT_W{1'b0}};
        end else if (pop_s) begin
            if (frame_end_s) begin
                pix_cnt_r <= {PIX_CNT_W{1'b0}};
            end else begin
                pix_cnt_r <= pix_cnt_r + PIX_CNT_W'(1);
            end
        end else begin
            pix_cnt_r <= pix_cnt_r;
        end
    end

    assign last_out = valid_s & is_last_ch(ch_idx_r) & frame_end_s;
`else
    assign last_out = 1'b0;
`endif

    // Occupancy and frame size are not needed by the control path itself.
    assign unused_s = ^{fifo_count_s, FRAME_PIX};

    // Storage is not reset, so the sample is masked whenever nothing is held.
    assign Out       = valid_s ? head_s[ch_idx_r] : {Datawidth{1'b0}};
    assign valid_out = valid_s;
    assign ch_idx    = ch_idx_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_conv_out_serializer_4ch.sv
// ---------------------------------------------------------------------------
// tb_conv_out_serializer_4ch
// Directed self-checking bench for conv_out_serializer_4ch with default
// parameters (32-bit samples, 4-pixel FIFO, 3x3 frame). Expected last_out
// behaviour follows SERIALIZER_FRAME_LAST_EN as seen by this compilation.
// ---------------------------------------------------------------------------
module tb_conv_out_serializer_4ch;
    import conv_out_serializer_4ch_pkg::*;

    localparam int DW = 32;
`ifdef SERIALIZER_FRAME_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                valid_in;
    logic [DW-1:0]       In_0;
    logic [DW-1:0]       In_1;
    logic [DW-1:0]       In_2;
    logic [DW-1:0]       In_3;
    logic                ready_in;
    logic                valid_out;
    logic [DW-1:0]       Out;
    logic [CH_IDX_W-1:0] ch_idx;
    logic                last_out;
    logic                overflow;

    int n_vec  = 0;
    int n_miss = 0;

    conv_out_serializer_4ch #(
        .Datawidth  (DW),
        .FIFO_DEPTH (4),
        .IMG_Width  (3),
        .IMG_Height (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .In_0      (In_0),
        .In_1      (In_1),
        .In_2      (In_2),
        .In_3      (In_3),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .Out       (Out),
        .ch_idx    (ch_idx),
        .last_out  (last_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pix_val(input int p, input int c);
        return 32'((p << 8) + c + 1);
    endfunction

    task automatic set_pix(input int p);
        In_0 = pix_val(p, 0);
        In_1 = pix_val(p, 1);
        In_2 = pix_val(p, 2);
        In_3 = pix_val(p, 3);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Expected output of one sample, state-dependent only.
    task automatic chk_sample(input string tag, input logic [31:0] exp_out, input int exp_ch);
        chk({tag, "_valid"}, 32'(valid_out), 32'd1);
        chk({tag, "_out"},   Out,             exp_out);
        chk({tag, "_ch"},    32'(ch_idx),    32'(exp_ch));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] t1 [4];
        bit          rdy_pat [7];
        int          e;
        int          t;
        int          lasts;
        int          sent;

        t1      = '{32'd10, 32'd20, 32'd30, 32'd40};
        rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        In_0 = '0; In_1 = '0; In_2 = '0; In_3 = '0;

        // Reset state
        do_reset();
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_out",   Out,            32'd0);
        chk("rst_ch",    32'(ch_idx),    32'd0);
        chk("rst_last",  32'(last_out),  32'd0);
        chk("rst_ovf",   32'(overflow),  32'd0);

        // Single pixel, ready held high
        ready_in = 1'b1;
        valid_in = 1'b1;
        In_0 = 32'd10; In_1 = 32'd20; In_2 = 32'd30; In_3 = 32'd40;
        chk("t1_pre_valid", 32'(valid_out), 32'd0);
        step();
        valid_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk_sample("t1", t1[c], c);
            chk("t1_last", 32'(last_out), 32'd0);
            step();
        end
        chk("t1_post_valid", 32'(valid_out), 32'd0);
        chk("t1_post_out",   Out,            32'd0);

        // Stalls: ready toggles, samples hold and come out once in order
        do_reset();
        set_pix(1);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        e = 0;
        for (int i = 0; i < 7; i++) begin
            ready_in = rdy_pat[i];
            chk_sample("t2", pix_val(1, e), e);
            step();
            if (rdy_pat[i]) e++;
        end
        chk("t2_count", 32'(e), 32'd4);
        chk("t2_done_valid", 32'(valid_out), 32'd0);

        // Overflow: five pixels into a 4-deep buffer with no draining
        do_reset();
        for (int p = 0; p < 5; p++) begin
            set_pix(p + 2);
            valid_in = 1'b1;
            step();
            if (p == 3) chk("t3_ovf_full", 32'(overflow), 32'd0);
        end
        valid_in = 1'b0;
        chk("t3_ovf_set", 32'(overflow), 32'd1);
        ready_in = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 4; c++) begin
                chk_sample("t3", pix_val(p + 2, c), c);
                step();
            end
        end
        chk("t3_drain_valid", 32'(valid_out), 32'd0);
        chk("t3_ovf_sticky",  32'(overflow),  32'd1);

        // Full buffer, new pixel coincides with the popping transfer
        do_reset();
        chk("t4_ovf_cleared", 32'(overflow), 32'd0);
        for (int p = 0; p < 4; p++) begin
            set_pix(p + 10);
            valid_in = 1'b1;
            step();
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk_sample("t4a", pix_val(10, c), c);
            step();
        end
        set_pix(14);
        valid_in = 1'b1;
        chk_sample("t4b", pix_val(10, 3), 3);
        step();
        valid_in = 1'b0;
        chk("t4_ovf", 32'(overflow), 32'd0);
        for (int p = 1; p < 5; p++) begin
            for (int c = 0; c < 4; c++) begin
                chk_sample("t4c", pix_val(p + 10, c), c);
                step();
            end
        end
        chk("t4_drain_valid", 32'(valid_out), 32'd0);

        // Two 3x3 frames, ready high, one pixel every 4 cycles
        do_reset();
        ready_in = 1'b1;
        t = 0;
        lasts = 0;
        sent = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            valid_in = ((cyc % 4) == 0) && (sent < 18);
            if (valid_in) begin
                set_pix(sent + 40);
                sent++;
            end
            if (valid_out) begin
                t++;
                chk("t5_last", 32'(last_out), 32'(LAST_EN && ((t % 36) == 0)));
                if (last_out) lasts++;
            end
            step();
        end
        valid_in = 1'b0;
        chk("t5_xfers", 32'(t),     32'd72);
        chk("t5_lasts", 32'(lasts), LAST_EN ? 32'd2 : 32'd0);

        // Asynchronous reset mid-pixel with two pixels buffered
        do_reset();
        for (int p = 0; p < 2; p++) begin
            set_pix(p + 20);
            valid_in = 1'b1;
            step();
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        step();
        step();
        chk_sample("t6_pre", pix_val(20, 2), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(valid_out), 32'd0);
        chk("t6_rst_out",   Out,            32'd0);
        chk("t6_rst_ch",    32'(ch_idx),    32'd0);
        chk("t6_rst_last",  32'(last_out),  32'd0);
        chk("t6_rst_ovf",   32'(overflow),  32'd0);
        #2;
        rst = 1'b1;
        ready_in = 1'b0;
        set_pix(30);
        valid_in = 1'b1;
        chk("t6_rel_valid", 32'(valid_out), 32'd0);
        step();
        valid_in = 1'b0;
        chk_sample("t6_post", pix_val(30, 0), 0);
        chk("t6_post_ovf", 32'(overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/conv_out_serializer_4ch.md
CONV_OUT_SERIALIZER_4CH -- requirements
Module: conv_out_serializer_4ch

Interface
REQ-001 Parameter Datawidth, default 32: width of each channel sample.
REQ-002 Parameter FIFO_DEPTH, default 4: number of 4-channel pixels buffered, power of two and at least 2.
REQ-003 Parameter IMG_Width, default 3: pixels per row.
REQ-004 Parameter IMG_Height, default 3: rows per frame.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port valid_in, input, 1 bit: In_0..In_3 hold a pixel this cycle; the upstream layer has no backpressure.
REQ-008 Ports In_0, In_1, In_2, In_3, input, Datawidth each: channel 0..3 samples of one pixel.
REQ-009 Port ready_in, input, 1 bit: the downstream consumer accepts Out this cycle.
REQ-010 Port valid_out, output, 1 bit: Out and ch_idx are valid.
REQ-011 Port Out, output, Datawidth: current channel sample.
REQ-012 Port ch_idx, output, 2 bits: channel number of Out (0..3).
REQ-013 Port last_out, output, 1 bit: Out is channel 3 of the final pixel of a frame.
REQ-014 Port overflow, output, 1 bit: sticky flag set when a pixel was dropped.

Function
REQ-015 On valid_in=1 with the FIFO not full, the block SHALL write {In_3,In_2,In_1,In_0} at the tail.
REQ-016 valid_out SHALL be 1 exactly when the FIFO is non-empty; Out and ch_idx are driven from the head entry, giving 1-cycle latency from valid_in to valid_out.
REQ-017 A transfer occurs when valid_out=1 and ready_in=1; ch_idx then advances 0->1->2->3.
REQ-018 A transfer at ch_idx=3 pops the head entry, and ch_idx wraps to 0.
REQ-019 While valid_out=1 and ready_in=0, Out, ch_idx and last_out SHALL hold stable.
REQ-020 Occupancy SHALL be tracked with a count of width clog2(FIFO_DEPTH)+1; read and write pointers wrap modulo FIFO_DEPTH.
REQ-021 If the FIFO is full and a pop occurs in the same cycle as valid_in=1, the incoming pixel SHALL be accepted.
REQ-022 If the FIFO is full, valid_in=1 and no pop occurs, the pixel SHALL be dropped, overflow SHALL be set to 1, and it stays 1 until reset.
REQ-023 If the FIFO is empty and valid_in=1, the pixel SHALL appear at the head in the next cycle with ch_idx=0.
REQ-024 A popped-pixel counter SHALL run 0..IMG_Width*IMG_Height-1 and wrap to 0.
REQ-025 last_out SHALL be 1 when valid_out=1, ch_idx=3 and the counter equals IMG_Width*IMG_Height-1.

Reset
REQ-026 While rst=0, the block SHALL asynchronously clear the FIFO pointers, count, ch_idx, pixel counter and overflow.
REQ-027 While rst=0, the outputs SHALL read valid_out=0, Out=0, ch_idx=0, last_out=0 and overflow=0.
REQ-028 A reset asserted mid-pixel or mid-frame SHALL discard all buffered data; the first pixel after release starts at ch_idx=0, pixel count 0.
REQ-029 FIFO storage contents SHALL NOT require reset; Out SHALL be masked to 0 whenever valid_out=0.

Configuration
REQ-030 Macro SERIALIZER_FRAME_LAST_EN defined: the pixel counter and last_out behave as in REQ-024 and REQ-025.
REQ-031 Macro SERIALIZER_FRAME_LAST_EN undefined: the pixel counter is not built, last_out is tied to 0, and all other behaviour is identical.

Structure
REQ-032 A shared package SHALL hold the channel count constant (4), the ch_idx width constant (2) and the packed 4-channel pixel typedef.
REQ-033 The buffer SHALL be a sub-module pixel_fifo (parameters width and depth, push/pop interface, full/empty/count outputs); the serializer control stays in the top module.

Verification
REQ-034 Single pixel In_0..In_3 = 10,20,30,40 with ready_in held 1 -> valid_out rises 1 cycle later; Out = 10,20,30,40 with ch_idx 0..3 on 4 consecutive cycles; then valid_out=0.
REQ-035 ready_in toggled 1,0,1,0 during a pixel -> Out and ch_idx hold through each stall; all 4 samples are delivered exactly once, in order.
REQ-036 With FIFO_DEPTH=4 and ready_in=0, 5 pixels on consecutive cycles -> the first 4 are retained, the 5th is dropped and overflow=1; after ready_in=1, exactly 16 samples are emitted.
REQ-037 FIFO full and valid_in coinciding with the ch_idx=3 transfer -> the new pixel is accepted, overflow stays 0, and the stream remains contiguous.
REQ-038 3x3 frame (9 pixels) streamed twice with ready_in=1 -> last_out=1 only on the 36th and 72nd transfers (SERIALIZER_FRAME_LAST_EN defined) and never (undefined).
REQ-039 rst pulsed low asynchronously at ch_idx=2 with 2 pixels buffered -> outputs go to 0 immediately; the next pixel after release emits from ch_idx=0 and overflow=0.
